// File: rtl/tiny_dnn_pkg.sv
// Shared types for the tiny_dnn host-side buffer block: sequencer states,
// latched layer geometry and the buffer address width.
package tiny_dnn_pkg;

  localparam int ADDR_W = 13;

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [3:0] id;
    logic [9:0] is;
    logic [4:0] ih;
    logic [4:0] iw;
    logic [3:0] od;
    logic [9:0] os;
    logic [4:0] oh;
    logic [4:0] ow;
    logic [2:0] kh;
    logic [2:0] kw;
  } geom_t;

endpackage

// File: rtl/tiny_dnn_buf_ram.sv
// Real-valued word buffer: asynchronous read port, synchronous write port
// and a registered host read port. Out-of-range accesses read 0.0 / are dropped.
module tiny_dnn_buf_ram
  import tiny_dnn_pkg::*;
#(
  parameter int DEPTH = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  real               wdata,
  input  logic [ADDR_W-1:0] raddr,
  output real               rdata,
  input  logic [ADDR_W-1:0] h_addr,
  output real               h_rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  real mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  always_comb begin
    rdata = 0.0;
    if (in_range(raddr)) rdata = mem[raddr[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) mem[waddr[IDX_W-1:0]] <= wdata;
  end

  // Non-blocking update means a same-cycle write is not visible here: old data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 h_rdata <= 0.0;
    else if (in_range(h_addr))  h_rdata <= mem[h_addr[IDX_W-1:0]];
    else                        h_rdata <= 0.0;
  end

endmodule

// File: rtl/tiny_dnn_buf.sv
// Host-side responder for tiny_dnn_top: owns the input/output buffers, latches
// one layer's geometry and sequences init / run / drain with a watchdog.
module tiny_dnn_buf
  import tiny_dnn_pkg::*;
#(
  parameter int IN_DEPTH  = 8192,
  parameter int OUT_DEPTH = 8192,
  parameter int TIMEOUT   = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_we,
  input  logic              h_sel,
  input  logic [ADDR_W-1:0] h_addr,
  input  real               h_wdata,
  output real               h_rdata,
  input  logic              start,
  input  logic [3:0]        cfg_id,
  input  logic [9:0]        cfg_is,
  input  logic [4:0]        cfg_ih,
  input  logic [4:0]        cfg_iw,
  input  logic [3:0]        cfg_od,
  input  logic [9:0]        cfg_os,
  input  logic [4:0]        cfg_oh,
  input  logic [4:0]        cfg_ow,
  input  logic [2:0]        cfg_kh,
  input  logic [2:0]        cfg_kw,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [13:0]       out_cnt,
  output logic              s_init,
  input  logic              s_fin,
  output logic              init,
  output logic              write,
  input  logic              exec,
  input  logic [ADDR_W-1:0] ia,
  output real               d,
  input  logic              outr,
  input  logic [ADDR_W-1:0] oa,
  input  real               x,
  output logic [3:0]        id,
  output logic [9:0]        is,
  output logic [4:0]        ih,
  output logic [4:0]        iw,
  output logic [3:0]        od,
  output logic [9:0]        os,
  output logic [4:0]        oh,
  output logic [4:0]        ow,
  output logic [2:0]        kh,
  output logic [2:0]        kw
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state;
  geom_t             geom;
  logic [WD_W-1:0]   wd;
  logic              quiet;
  logic              h_sel_q;
  logic              ia_ok, oa_ok, host_ok;
  logic              ibuf_we, obuf_we;
  logic [ADDR_W-1:0] obuf_waddr;
  real               obuf_wdata;
  real               ibuf_h_rdata, obuf_h_rdata, obuf_rd_unused;

  assign init  = 1'b0;
  assign write = 1'b0;

  assign ia_ok   = 32'(ia) < 32'(IN_DEPTH);
  assign oa_ok   = 32'(oa) < 32'(OUT_DEPTH);
  assign host_ok = h_we && (state == IDLE);

  // busy and IDLE never overlap, so the accelerator and host never share the obuf write port.
  assign ibuf_we    = host_ok && !h_sel;
  assign obuf_we    = (busy && outr && oa_ok) || (host_ok && h_sel);
  assign obuf_waddr = busy ? oa : h_addr;
  assign obuf_wdata = busy ? x : h_wdata;

  tiny_dnn_buf_ram #(.DEPTH(IN_DEPTH)) u_ibuf (
    .clk(clk), .rst_n(rst_n),
    .we(ibuf_we), .waddr(h_addr), .wdata(h_wdata),
    .raddr(ia), .rdata(d),
    .h_addr(h_addr), .h_rdata(ibuf_h_rdata)
  );

  tiny_dnn_buf_ram #(.DEPTH(OUT_DEPTH)) u_obuf (
    .clk(clk), .rst_n(rst_n),
    .we(obuf_we), .waddr(obuf_waddr), .wdata(obuf_wdata),
    .raddr(oa), .rdata(obuf_rd_unused),
    .h_addr(h_addr), .h_rdata(obuf_h_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) h_sel_q <= 1'b0;
    else        h_sel_q <= h_sel;
  end

  assign h_rdata = h_sel_q ? obuf_h_rdata : ibuf_h_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      geom    <= '0;
      wd      <= '0;
      quiet   <= 1'b0;
      s_init  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      out_cnt <= '0;
    end else begin
      s_init <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          geom    <= '{id: cfg_id, is: cfg_is, ih: cfg_ih, iw: cfg_iw,
                       od: cfg_od, os: cfg_os, oh: cfg_oh, ow: cfg_ow,
                       kh: cfg_kh, kw: cfg_kw};
          out_cnt <= '0;
          err     <= 1'b0;
          busy    <= 1'b1;
          s_init  <= 1'b1;
          state   <= INIT;
        end
        INIT: begin
          wd    <= WD_W'(TIMEOUT - 1);
          state <= RUN;
        end
        RUN, DRAIN: begin
          // Watchdog spans RUN and DRAIN; terminal count aborts without done.
          if (wd == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wd <= wd - 1'b1;
            if (state == RUN) begin
              if (s_fin) begin
                quiet <= 1'b0;
                state <= DRAIN;
              end
            end else if (outr) begin
              quiet <= 1'b0;
            end else if (quiet) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              quiet <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (busy && outr && (out_cnt != 14'h3fff)) out_cnt <= out_cnt + 1'b1;
      if ((exec && !ia_ok) || (busy && outr && !oa_ok) || (h_we && busy)) err <= 1'b1;
    end
  end

  assign id = geom.id;
  assign is = geom.is;
  assign ih = geom.ih;
  assign iw = geom.iw;
  assign od = geom.od;
  assign os = geom.os;
  assign oh = geom.oh;
  assign ow = geom.ow;
  assign kh = geom.kh;
  assign kw = geom.kw;

endmodule

// File: doc/tiny_dnn_buf.md
Name: tiny_dnn_buf

Overview:
Host-side responder for the tiny_dnn_top compute interface. It owns the input-activation buffer and the output buffer, and latches one layer's geometry and drives it onto the accelerator. It pulses s_init, answers every exec/ia read with d, and captures each outr/oa/x write into the output buffer. Weight loading is out of scope: init and write are tied low. The block sits between the host load/readback port and tiny_dnn_top.

Parameters:
IN_DEPTH, 8192, input buffer words (at most 2^13)
OUT_DEPTH, 8192, output buffer words (at most 2^13)
TIMEOUT, 1048576, maximum RUN+DRAIN cycles before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
h_we  in  1  host write strobe
h_sel  in  1  0 = input buffer, 1 = output buffer
h_addr  in  13  host word address
h_wdata  in  real  host write data
h_rdata  out  real  host read data, 1-cycle latency
start  in  1  start one layer (pulse)
cfg_id/cfg_is/cfg_ih/cfg_iw  in  4/10/5/5  input depth-1, plane stride, height, width
cfg_od/cfg_os/cfg_oh/cfg_ow  in  4/10/5/5  output depth-1, plane stride, height, width
cfg_kh/cfg_kw  in  3/3  kernel height-1, width-1
busy  out  1  layer in progress
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky: timeout, out-of-range access, or host write while busy; cleared by start
out_cnt  out  14  outputs captured this layer
s_init  out  1  to accelerator
s_fin  in  1  from accelerator
init, write  out  1  tied 0
exec  in  1  accelerator read strobe
ia  in  13  read address
d  out  real  read data
outr  in  1  accelerator write strobe
oa  in  13  write address
x  in  real  write data
id..kw  out  as cfg_*  latched geometry to accelerator

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; s_init, busy, done, err = 0; out_cnt = 0; latched geometry = 0; h_rdata = 0.0. Buffer contents are not reset.
- States:
  - IDLE -> INIT on start. Latch all cfg_* into the geometry registers, clear out_cnt, clear err, busy = 1.
  - INIT: s_init = 1 for exactly one cycle, then go to RUN.
  - RUN: wait for s_fin = 1, then go to DRAIN.
  - DRAIN: wait until outr has been 0 for 2 consecutive cycles, then go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- start is ignored outside IDLE.
- s_fin is ignored outside RUN.
- Watchdog counter runs in RUN and DRAIN. On reaching TIMEOUT: err = 1, go to IDLE, busy = 0, no done pulse.
- Read path: d = ibuf[ia], combinational, in the same cycle as ia. This is required because the accelerator consumes d in the cycle ia is presented.
  - If ia >= IN_DEPTH, d = 0.0.
  - If that out-of-range read happens while exec = 1, err is set.
  - d is valid regardless of exec.
- Write path: at each posedge with outr = 1 and busy = 1: obuf[oa] <= x and out_cnt increments.
  - If oa >= OUT_DEPTH, the write is dropped, err is set, and out_cnt still increments.
  - outr while not busy is ignored.
- Host port:
  - h_we in IDLE writes the selected buffer.
  - h_we while busy is dropped and sets err.
  - Host reads (h_we = 0) are allowed in every state; h_rdata returns the selected buffer word one cycle later.
  - A host read of obuf in the same cycle as an accelerator write to the same address returns the old value.
- out_cnt saturates at 16383.
- Reset mid-layer: returns to IDLE immediately. The accelerator is not flushed; the host must issue start again.

Decomposition:
- Package tiny_dnn_pkg holds:
  - state enum {IDLE, INIT, RUN, DRAIN, DONE};
  - geometry struct (id, is, ih, iw, od, os, oh, ow, kh, kw);
  - address width constant (13).
- Sub-module tiny_dnn_buf_ram: one instance per buffer. Each has a real-typed array, an asynchronous read port and a synchronous write port, plus a registered host read port. The input buffer uses the asynchronous port for d; the output buffer uses the synchronous write port for x.

Test Plan:
1. Host writes ibuf[5] = 2.5 and ibuf[8191] = -1.0; drive ia = 5 then ia = 8191 -> d = 2.5 then -1.0, same cycle; err stays 0.
2. start with cfg_od = 3, cfg_kw = 2 -> geometry outputs match next cycle; s_init high exactly one cycle, 1 cycle after start; busy = 1.
3. Model drives outr for 4 cycles with oa = 0, 10, 20, 30 and x = 1.0..4.0, then s_fin, then outr low for 2 cycles -> obuf holds those values; out_cnt = 4; done pulses once; busy drops.
4. Host write during RUN to ibuf[0] -> write dropped; ibuf[0] unchanged; err = 1; next start clears err.
5. Set TIMEOUT = 100 and never assert s_fin -> after 100 cycles in RUN: err = 1, IDLE, no done pulse.
6. rst_n low mid-RUN for 1 cycle -> busy = 0, out_cnt = 0 and s_init = 0 asynchronously; a following start runs normally.
